saturn_bus_fetch: RTL

//  Instruction-fetch side of the PC/RSTK unit: turns its PC into Saturn bus traffic and returns nibbles.
//  On reset or PC reload it sends LOAD_PC + 5 address nibbles, then PC_READ, then one read per phase cycle.
//  o_nibble feeds the decoder and PC/RSTK unit; o_busy drives their i_bus_busy stall input.

---
 rtl/saturn_bus_fetch.sv | 139 +++++++++++++
 1 files changed

// File: rtl/saturn_bus_fetch.sv
// Saturn bus instruction fetch: sends LOAD_PC + 5 address nibbles + PC_READ, then one read per cycle.
// Optional shadow/architectural PC cross-check is built when SATURN_FETCH_PC_CHECK_EN is defined.
module saturn_bus_fetch #(
  parameter logic [3:0] CMD_LOAD_PC = 4'h4,
  parameter logic [3:0] CMD_PC_READ = 4'h2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [3:0]  i_phases,
  input  logic [19:0] i_current_pc,
  input  logic        i_reload_pc,
  output logic        o_bus_strobe,
  output logic        o_bus_cmd_data,
  output logic [3:0]  o_bus_nibble_out,
  input  logic [3:0]  i_bus_nibble_in,
  output logic [3:0]  o_nibble,
  output logic        o_nibble_valid,
  output logic        o_busy,
  output logic        o_pc_mismatch
);

  localparam logic [2:0] ST_START   = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_ADDR    = 3'd2;
  localparam logic [2:0] ST_READCMD = 3'd3;
  localparam logic [2:0] ST_FETCH   = 3'd4;

  logic [2:0]  state;
  logic [19:0] shadow_pc;
  logic [2:0]  load_cnt;
  logic        reload_prev;
  logic        rd_pending;
  logic        reload_rise;
  logic        pc_bad;
  logic [3:0]  addr_nibble;

  assign reload_rise = i_reload_pc & ~reload_prev;

`ifdef SATURN_FETCH_PC_CHECK_EN
  // The shadow PC has already advanced past the nibble being returned, hence the -1.
  logic [19:0] shadow_prev;
  assign shadow_prev = shadow_pc - 20'd1;
  assign pc_bad = (state == ST_FETCH) && i_phases[1] && (shadow_prev != i_current_pc);
`else
  assign pc_bad = 1'b0;
`endif

  always_comb begin
    addr_nibble = shadow_pc[19:16];
    case (load_cnt)
      3'd0:    addr_nibble = shadow_pc[3:0];
      3'd1:    addr_nibble = shadow_pc[7:4];
      3'd2:    addr_nibble = shadow_pc[11:8];
      3'd3:    addr_nibble = shadow_pc[15:12];
      default: addr_nibble = shadow_pc[19:16];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state            <= ST_START;
      shadow_pc        <= 20'h00000;
      load_cnt         <= 3'd0;
      reload_prev      <= 1'b0;
      rd_pending       <= 1'b0;
      o_bus_strobe     <= 1'b0;
      o_bus_cmd_data   <= 1'b0;
      o_bus_nibble_out <= 4'h0;
      o_nibble         <= 4'h0;
      o_nibble_valid   <= 1'b0;
      o_busy           <= 1'b1;
      o_pc_mismatch    <= 1'b0;
    end else if (i_clk_en) begin
      reload_prev   <= i_reload_pc;
      o_bus_strobe  <= 1'b0;
      o_pc_mismatch <= 1'b0;
      // A reload (explicit or from a PC disagreement) pre-empts any transfer this cycle.
      if (reload_rise || pc_bad) begin
        shadow_pc      <= i_current_pc;
        state          <= ST_CMD;
        load_cnt       <= 3'd0;
        rd_pending     <= 1'b0;
        o_busy         <= 1'b1;
        o_nibble_valid <= 1'b0;
        o_pc_mismatch  <= pc_bad & ~reload_rise;
      end else begin
        case (state)
          ST_START: begin
            shadow_pc <= i_current_pc;
            state     <= ST_CMD;
          end
          ST_CMD: begin
            o_bus_strobe     <= 1'b1;
            o_bus_cmd_data   <= 1'b1;
            o_bus_nibble_out <= CMD_LOAD_PC;
            load_cnt         <= 3'd0;
            state            <= ST_ADDR;
          end
          ST_ADDR: begin
            o_bus_strobe     <= 1'b1;
            o_bus_cmd_data   <= 1'b1;
            o_bus_nibble_out <= addr_nibble;
            if (load_cnt == 3'd4) begin
              state <= ST_READCMD;
            end else begin
              load_cnt <= load_cnt + 3'd1;
            end
          end
          ST_READCMD: begin
            o_bus_strobe     <= 1'b1;
            o_bus_cmd_data   <= 1'b1;
            o_bus_nibble_out <= CMD_PC_READ;
            o_busy           <= 1'b0;
            state            <= ST_FETCH;
          end
          ST_FETCH: begin
            if (i_phases[0]) begin
              o_bus_strobe   <= 1'b1;
              o_bus_cmd_data <= 1'b0;
              o_nibble_valid <= 1'b0;
              rd_pending     <= 1'b1;
              shadow_pc      <= shadow_pc + 20'd1;
            end else if (i_phases[1] && rd_pending) begin
              o_nibble       <= i_bus_nibble_in;
              o_nibble_valid <= 1'b1;
              rd_pending     <= 1'b0;
            end
          end
          default: begin
            state  <= ST_START;
            o_busy <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
